cache_mem_arbiter: RTL

Two-requester arbiter that shares one backing-memory port between cache controllers, such as an I-cache and a D-cache controller issuing writeback and allocate transfers. Each requester presents a single-word request and holds it until acknowledged. The arbiter grants requesters round-robin, registers the winning request onto the memory port, waits for `mem_ready`, then returns read data with a one-cycle acknowledge. It sits between the cache FSMs and the memory model/controller.

---
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin share of one memory port between two cache requesters.
// Define CACHE_ARB_LOCK_EN to let a locked requester keep the next grant once.
module cache_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gid_q, gid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              lock_q, lock_d;
  logic              used_q, used_d;
  logic              win;
  logic              hold;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      r0_req && r1_req:  win = rr_q;
      r1_req && !r0_req: win = 1'b1;
      default:           win = 1'b0;
    endcase
  end

  // A lock earns one extra grant; the completion after that always toggles.
`ifdef CACHE_ARB_LOCK_EN
  assign hold = lock_q && !used_q;
`else
  logic unused_lock;
  assign hold        = 1'b0;
  assign unused_lock = lock_q ^ used_q;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    lock_d  = lock_q;
    used_d  = used_q;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d = ISSUE;
          gid_d   = win;
          we_d    = win ? r1_we    : r0_we;
          addr_d  = win ? r1_addr  : r0_addr;
          wdata_d = win ? r1_wdata : r0_wdata;
          lock_d  = win ? r1_lock  : r0_lock;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = RESP;
          if (!we_q) begin
            if (gid_q) rd1_d = mem_rdata;
            else       rd0_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        rr_d    = hold ? gid_q : ~gid_q;
        used_d  = hold;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      lock_q  <= 1'b0;
      used_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      lock_q  <= lock_d;
      used_q  <= used_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign r0_ack    = (state_q == RESP) && !gid_q;
  assign r1_ack    = (state_q == RESP) && gid_q;
  assign r0_rdata  = rd0_q;
  assign r1_rdata  = rd1_q;

endmodule
